// File: rtl/wide_compare_sequencer_pkg.sv
// Shared definitions for the multi-cycle wide magnitude comparator:
// controller state encoding, slice width and operand-width helpers.
package wide_compare_sequencer_pkg;

    // Width of the single shared comparator slice.
    localparam int SLICE_W = 3;

    // Widest operand the 4-bit step counter can describe (15 slices).
    localparam int MAX_WIDTH = 45;

    // Controller states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Number of slices an operand of the given width splits into.
    function automatic int chunks_of(input int width);
        return width / SLICE_W;
    endfunction

    // Legal widths are whole multiples of the slice width within range.
    function automatic bit width_is_legal(input int width);
        return (width % SLICE_W == 0) && (width >= SLICE_W) && (width <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/wide_compare_sequencer_cmp3_slice.sv
// Purely combinational 3-bit unsigned magnitude comparator slice.
// Exactly one of gt, lt, eq is high for any input pair.
module cmp3_slice
    import wide_compare_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    output logic               gt,
    output logic               lt,
    output logic               eq
);

    assign gt = (a > b);
    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/wide_compare_sequencer.sv
// Multi-cycle WIDTH-bit unsigned magnitude comparator. Operands are captured
// on an accepted start and compared one 3-bit slice per clock, most
// significant slice first, stopping at the first unequal slice. A single
// shared cmp3_slice instance is time-multiplexed across the slices.
module wide_compare_sequencer
    import wide_compare_sequencer_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic [3:0]       steps
);

    localparam int CHUNKS = chunks_of(WIDTH);
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHUNKS - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [3:0]       CNT_ONE  = 4'd1;

    // Reject unsupported operand widths at elaboration.
    generate
        if (!width_is_legal(WIDTH)) begin : g_bad_width
            $error("wide_compare_sequencer: WIDTH must be a multiple of 3 in 3..45");
        end
    endgenerate

    // Controller state and registered outputs.
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               gt_q, gt_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic [3:0]         steps_q, steps_d;

    // Slice views of the captured operands and the idx-selected pair.
    logic [SLICE_W-1:0] a_slice [CHUNKS];
    logic [SLICE_W-1:0] b_slice [CHUNKS];
    logic [SLICE_W-1:0] a_sel;
    logic [SLICE_W-1:0] b_sel;
    logic               s_gt;
    logic               s_lt;
    logic               s_eq;

    // Split the captured operands into per-slice views.
    generate
        for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_slices
            assign a_slice[gi] = op_a_q[gi*SLICE_W +: SLICE_W];
            assign b_slice[gi] = op_b_q[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    // Route the slice pointed at by idx to the shared comparator.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sel = a_slice[i];
                b_sel = b_slice[i];
            end
        end
    end

    cmp3_slice u_cmp3_slice (
        .a  (a_sel),
        .b  (b_sel),
        .gt (s_gt),
        .lt (s_lt),
        .eq (s_eq)
    );

    // Next-state logic: capture on start, walk slices MSB first, stop early.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        steps_d = steps_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    idx_d   = IDX_LAST;
                    cnt_d   = CNT_ONE;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    eq_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!s_eq) begin
                    // First unequal slice decides the whole comparison.
                    gt_d    = s_gt;
                    lt_d    = s_lt;
                    steps_d = cnt_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (idx_q == IDX_ZERO) begin
                    // Every slice matched, operands are equal.
                    eq_d    = 1'b1;
                    steps_d = cnt_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any comparison in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            steps_q <= steps_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign gt    = gt_q;
    assign lt    = lt_q;
    assign eq    = eq_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_wide_compare_sequencer.sv
// Scoreboard bench for wide_compare_sequencer (WIDTH=12). The driver pushes
// the reference result for every accepted start; an independent monitor
// checks busy/done/flags/steps and the start-to-done latency each cycle.
module tb_wide_compare_sequencer;

    localparam int WIDTH  = 12;
    localparam int CHUNKS = WIDTH / 3;

    typedef struct {
        logic gt;
        logic lt;
        logic eq;
        int   steps;
        int   accept;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, gt, lt, eq;
    logic [3:0]       steps;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];

    wide_compare_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq),
        .steps (steps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: decided by the most significant 3-bit digit that differs.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        exp_t e;
        int xi = int'(x);
        int yi = int'(y);
        e.gt = (xi > yi);
        e.lt = (xi < yi);
        e.eq = (xi == yi);
        e.steps = CHUNKS;
        e.accept = 0;
        for (int c = CHUNKS - 1; c >= 0; c--) begin
            if ((xi / (8 ** c)) % 8 != (yi / (8 ** c)) % 8) begin
                e.steps = CHUNKS - c;
                break;
            end
        end
        return e;
    endfunction

    // Monitor: compares DUT outputs against the oldest outstanding request.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            if (q.size() > 0) begin
                if (cyc < q[0].accept + q[0].steps) begin
                    chk("busy_in_run", int'(busy), 1);
                    chk("done_in_run", int'(done), 0);
                    chk("flags_clear_in_run", int'({gt, lt, eq}), 0);
                end else begin
                    chk("done_at_latency", int'(done), 1);
                    chk("busy_at_done", int'(busy), 0);
                    chk("gt", int'(gt), int'(q[0].gt));
                    chk("lt", int'(lt), int'(q[0].lt));
                    chk("eq", int'(eq), int'(q[0].eq));
                    chk("steps", int'(steps), q[0].steps);
                    $display("txn accept=%0d done=%0d gt=%0d lt=%0d eq=%0d steps=%0d",
                             q[0].accept, cyc, gt, lt, eq, steps);
                    void'(q.pop_front());
                end
            end else if (done) begin
                chk("unexpected_done", 1, 0);
            end
        end
    end

    // Issue one compare from a negedge with the DUT idle; return at the
    // negedge of the done cycle so the caller may start back-to-back.
    task automatic run_one(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                           input bit noisy);
        exp_t e;
        int   n = 0;
        e = model(ta, tb_v);
        start = 1'b1;
        a = ta;
        b = tb_v;
        @(posedge clk);
        #1;
        e.accept = cyc;
        q.push_back(e);
        forever begin
            @(negedge clk);
            if (done) break;
            n++;
            if (n > 40) begin
                chk("done_timeout", 0, 1);
                break;
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                a = WIDTH'($urandom);
                b = WIDTH'($urandom);
            end else begin
                start = 1'b0;
            end
        end
    endtask

    task automatic idle_gap(input int n);
        start = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int dsum;

        // Power-up reset values.
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({gt, lt, eq}), 0);
        chk("rst_steps", int'(steps), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_one(12'hA53, 12'hA53, 1'b0);
        idle_gap(1);
        run_one(12'h800, 12'h7FF, 1'b0);
        idle_gap(2);
        run_one(12'h123, 12'h124, 1'b0);
        idle_gap(1);
        // Start pulses during RUN, then start held through the done cycle.
        run_one(12'h555, 12'h555, 1'b1);
        run_one(12'h001, 12'h000, 1'b1);
        run_one(12'h000, 12'hFFF, 1'b0);
        run_one(12'hFFF, 12'hFFF, 1'b1);

        // Randomized compares; b often shares leading slices with a.
        for (int t = 0; t < 60; t++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = WIDTH'($urandom);
                1: rb = ra;
                default: rb = ra ^ (WIDTH'($urandom_range(1, 7)) << (3 * $urandom_range(0, CHUNKS - 1)));
            endcase
            run_one(ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
        end

        // Reset during cycle 2 of an equal-operand compare.
        idle_gap(1);
        start = 1'b1;
        a = 12'h3C3;
        b = 12'h3C3;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        q.delete();
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_flags", int'({gt, lt, eq}), 0);
        chk("abort_steps", int'(steps), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dsum = 0;
        repeat (6) begin
            @(negedge clk);
            dsum += int'(done) + int'(busy);
        end
        chk("no_done_after_abort", dsum, 0);
        run_one(12'h3C3, 12'h3C2, 1'b0);
        idle_gap(3);
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
